// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared FSM encoding, strobe constants and address helpers for the data-memory target
package riscv_mem_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    localparam logic [3:0] WSTRB_FULL = 4'b1111;
    localparam int BYTE_OFS_W = 2;
    // Range check on the word index so 4*depth never has to be formed in 32 bits
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[BYTE_OFS_W-1:0] != '0) || ((addr >> BYTE_OFS_W) >= depth);
    endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response valid-ready channels between the core and the data memory
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master(
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave(
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 storage with byte write enables, combinational read and async clear
module dmem_array #(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int b = 0; b < 4; b++) if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end
    assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time load/store target with programmable wait states and error flagging
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_wstrb;
    logic        acc_write;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_wstrb;
    logic        accept, do_access, err;
    logic [3:0]  be;
    logic [31:0] mem_rdata, rdata_q;
    logic        err_q;
    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign accept        = bus.req_valid && bus.req_ready;
    // A zero-wait build accesses on the accept edge, before the latch holds the payload
    assign acc_write = (state == IDLE) ? bus.req_write : lat_write;
    assign acc_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
    assign acc_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;
    assign acc_wstrb = (state == IDLE) ? bus.req_wstrb : lat_wstrb;
    assign err       = addr_err(acc_addr, DEPTH);
    assign do_access = (state == IDLE) ? (accept && WAIT_CYCLES == 0) : (state == WAIT && cnt == 4'd1);
    assign be        = (do_access && acc_write && !err) ? acc_wstrb : 4'b0000;
    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk(clk),
        .rst(rst),
        .addr(acc_addr[AW+BYTE_OFS_W-1:BYTE_OFS_W]),
        .be(be),
        .wdata(acc_wdata),
        .rdata(mem_rdata)
    );
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt       <= 4'(WAIT_CYCLES);
                lat_write <= bus.req_write;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                lat_wstrb <= bus.req_wstrb;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rdata_q <= (acc_write || err) ? '0 : mem_rdata;
                err_q   <= err;
            end else if (bus.rsp_valid && bus.rsp_ready) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed load/store vectors with a scoreboard queue checked by a response monitor
module tb_dmem_responder;
    import riscv_mem_pkg::*;
    localparam int WAIT_CYCLES = 2;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    always #5 clk = ~clk;
    dmem_responder_if bus();
    dmem_responder_if bus0();
    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(WAIT_CYCLES)) dut (.clk(clk), .rst(rst), .bus(bus));
    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every completed response handshake consumes one expectation
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with nothing expected", bus.rsp_rdata, bus.rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] er, input logic ee);
        int n;
        exp_q.push_back('{rdata: er, err: ee});
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = ~w;
        bus.req_addr  = 32'h0000_0003;
        bus.req_wdata = ~d;
        bus.req_wstrb = ~s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 40);
        chk("latency", 32'(n), 32'(WAIT_CYCLES + 1));
    endtask

    initial begin
        int   last_acc;
        int   nrsp;
        logic seen;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wstrb  = '0;
        bus.rsp_ready  = 1'b1;
        bus0.req_valid = 1'b0;
        bus0.req_write = 1'b0;
        bus0.req_addr  = '0;
        bus0.req_wdata = '0;
        bus0.req_wstrb = '0;
        bus0.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_in_rst", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);

        send(1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 1'b0);
        send(1'b1, 32'h0C, 32'hDEADBEEF, WSTRB_FULL, 32'h0, 1'b0);
        send(1'b0, 32'h0C, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        send(1'b1, 32'h0C, 32'h11223344, 4'b0101, 32'h0, 1'b0);
        send(1'b0, 32'h0C, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
        send(1'b0, 32'h0E, 32'h0, 4'h0, 32'h0, 1'b1);
        send(1'b1, 32'h100, 32'hAAAAAAAA, WSTRB_FULL, 32'h0, 1'b1);
        send(1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 1'b0);
        send(1'b1, 32'h0C, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
        send(1'b0, 32'h0C, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
        send(1'b1, 32'hFC, 32'h12345678, WSTRB_FULL, 32'h0, 1'b0);
        send(1'b0, 32'hFC, 32'h0, 4'h0, 32'h12345678, 1'b0);
        send(1'b1, 32'h0000_0001, 32'h55555555, WSTRB_FULL, 32'h0, 1'b1);
        send(1'b0, 32'h00, 32'h0, 4'h0, 32'h0, 1'b0);

        // Backpressure: response must hold while rsp_ready is low
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        send(1'b0, 32'h0C, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", bus.rsp_rdata, 32'hDE22BE44);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_still_low", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("bp_ready_after", 32'(bus.req_ready), 32'd1);
        chk("bp_valid_cleared", 32'(bus.rsp_valid), 32'd0);
        chk("bp_rdata_cleared", bus.rsp_rdata, 32'd0);

        // Reset during WAIT of a store: dropped with no response
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h04;
        bus.req_wdata = 32'hCAFEBABE;
        bus.req_wstrb = WSTRB_FULL;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_in_wait", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        chk("midrst_no_rsp", 32'(seen), 32'd0);
        send(1'b0, 32'h04, 32'h0, 4'h0, 32'h0, 1'b0);
        send(1'b0, 32'h0C, 32'h0, 4'h0, 32'h0, 1'b0);
        send(1'b0, 32'hFC, 32'h0, 4'h0, 32'h0, 1'b0);

        // Zero-wait instance: store, then back-to-back loads with req_valid held
        @(negedge clk);
        bus0.req_valid = 1'b1;
        bus0.req_write = 1'b1;
        bus0.req_addr  = 32'h08;
        bus0.req_wdata = 32'hCAFEF00D;
        bus0.req_wstrb = WSTRB_FULL;
        chk("zw_ready", 32'(bus0.req_ready), 32'd1);
        @(negedge clk);
        chk("zw_st_valid", 32'(bus0.rsp_valid), 32'd1);
        chk("zw_st_rdata", bus0.rsp_rdata, 32'd0);
        chk("zw_st_ready_low", 32'(bus0.req_ready), 32'd0);
        bus0.req_write = 1'b0;
        last_acc = -1;
        nrsp = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus0.rsp_valid) begin
                nrsp++;
                chk("zw_ld_rdata", bus0.rsp_rdata, 32'hCAFEF00D);
                chk("zw_ld_err", 32'(bus0.rsp_err), 32'd0);
                chk("zw_ld_latency", 32'(c - last_acc), 32'd1);
            end
            if (bus0.req_ready) begin
                if (last_acc >= 0) chk("zw_interval", 32'(c - last_acc), 32'd2);
                last_acc = c;
            end
        end
        bus0.req_valid = 1'b0;
        chk("zw_rsp_count", 32'(nrsp), 32'd4);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory target that services load/store requests issued by the RISC-V core's memory stage.
- It replaces the zero-latency combinational data memory when the core moves to a multi-cycle/stall-capable memory interface.
- Accepts one request at a time over a valid/ready channel, inserts a programmable number of wait states, then returns a response on a second valid/ready channel.
- Supports byte-strobed writes and flags misaligned or out-of-range accesses.

Parameters:
- DEPTH, 64, number of 32-bit words in the storage array; power of two.
- WAIT_CYCLES, 2, wait states between request acceptance and response; range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte-lane enables for stores; bit i enables byte i (bits 8i+7:8i).
- rsp_valid  output  1  response available.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and for errors.
- rsp_err  output  1  access was misaligned or out of range.

Behaviour:
- Reset: the clock is clk and the reset is rst, which is asynchronous and active-high.
- Reset values: state = IDLE, req_ready = 1 once rst deasserts, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0, all DEPTH words cleared to 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready at a rising edge, latch write, addr, wdata and wstrb.
  - If WAIT_CYCLES == 0, go to RESP and perform the access on the same edge.
  - Otherwise go to WAIT with cnt = WAIT_CYCLES.
- WAIT:
  - req_ready = 0.
  - If cnt == 1, go to RESP and perform the access on that edge; else cnt = cnt - 1.
  - Duration is exactly WAIT_CYCLES cycles.
- RESP:
  - req_ready = 0, rsp_valid = 1.
  - rsp_rdata and rsp_err are registered and held stable until rsp_valid & rsp_ready.
  - On that handshake, return to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
  - Backpressure (rsp_ready = 0) may hold RESP indefinitely.
- Latency: a request accepted in cycle N has rsp_valid high from cycle N+1+WAIT_CYCLES.
  - Minimum initiation interval is WAIT_CYCLES+2 cycles; there is no request pipelining or overlap.
- Address rules:
  - Word index = req_addr[log2(DEPTH)+1:2].
  - Error if req_addr[1:0] != 0 (misaligned).
  - Error if req_addr >= 4*DEPTH (out of range).
  - On error: no array write, rsp_rdata = 0, rsp_err = 1.
- Load access: rsp_rdata = array[index] as of the access edge.
- Store access:
  - Only the byte lanes with req_wstrb[i] = 1 are updated.
  - req_wstrb = 0000 is a legal no-op store with rsp_err = 0.
  - rsp_rdata = 0.
- Requests while busy: req_valid asserted outside IDLE is ignored; the core must hold req_valid and its payload until req_ready.
- Reset mid-operation: the pending request is dropped with no response, the array is cleared, and the FSM returns to IDLE.
- Simultaneous rsp handshake and new req_valid: the new request is not accepted in that cycle (req_ready = 0 in RESP); it is accepted the following cycle in IDLE.

Decomposition:
- Shared package riscv_mem_pkg:
  - state encoding (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2);
  - WSTRB_FULL = 4'b1111;
  - word/byte address helper constants (BYTE_OFS_W = 2).
- Sub-module dmem_array: DEPTH x 32 storage with asynchronous clear on rst, a per-byte write-enable port, and a combinational read port.
- dmem_responder holds the FSM, the wait counter, the request latch, the error check and the response registers.

Test Plan:
- Basic store/load: store addr 0x0000000C, wdata 0xDEADBEEF, wstrb 1111, then load 0x0C.
  - rsp_rdata = 0xDEADBEEF, rsp_err = 0.
  - rsp_valid rises exactly 3 cycles after each accept (WAIT_CYCLES = 2).
- Byte strobes: after the store above, store addr 0x0C, wdata 0x11223344, wstrb 0101, then load 0x0C.
  - rsp_rdata = 0xDE22BE44.
- Errors:
  - Load 0x0000000E gives rsp_err = 1, rsp_rdata = 0.
  - Store to 0x00000100 (DEPTH = 64) gives rsp_err = 1, and a following load of 0x00 still returns 0.
- Backpressure: hold rsp_ready = 0 for 5 cycles during a load of 0x0C.
  - rsp_valid and rsp_rdata stay stable throughout; req_ready stays 0.
  - One cycle after rsp_ready = 1, req_ready = 1.
- Zero-wait build (WAIT_CYCLES = 0): back-to-back load requests.
  - rsp_valid appears one cycle after each accept; accepts are spaced 2 cycles apart.
- Reset mid-operation: assert rst one cycle into WAIT of a store to 0x04.
  - rsp_valid = 0 immediately; no response is ever produced.
  - A subsequent load of 0x04 returns 0.
